// File: rtl/mac_job_sequencer.sv
// Job sequencer for one MAC block: takes a job descriptor, streams operand
// beats into the MAC, waits out its one-cycle latency and returns the result.
module mac_job_sequencer #(
    parameter int MIN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int CONF_WIDTH = 3,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [1:0]                  job_mode,
    input  logic                        job_acc,
    input  logic [ACC_WIDTH-1:0]        job_init,
    input  logic [LEN_WIDTH-1:0]        job_len,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [MIN_WIDTH-1:0]        op_b,
    input  logic [4*MIN_WIDTH-1:0]      op_a,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ACC_WIDTH-1:0]        res_data,
    output logic                        res_err,
    output logic                        mac_rst,
    output logic                        mac_en,
    output logic [MIN_WIDTH-1:0]        mac_b,
    output logic [MIN_WIDTH-1:0]        mac_a0,
    output logic [MIN_WIDTH-1:0]        mac_a1,
    output logic [MIN_WIDTH-1:0]        mac_a2,
    output logic [MIN_WIDTH-1:0]        mac_a3,
    output logic [ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg,
    input  logic [ACC_WIDTH-1:0]        mac_c
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [1:0]             mode_q;
    logic                   acc_q;
    logic [ACC_WIDTH-1:0]   init_q;
    logic                   len_zero_q;
    logic                   zero_res;

    // Reserved mode and empty multiply-only jobs never trust the MAC output.
    assign zero_res = (mode_q == 2'd3) || (!acc_q && len_zero_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mode_q     <= '0;
            acc_q      <= 1'b0;
            init_q     <= '0;
            len_zero_q <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        mode_q     <= job_mode;
                        acc_q      <= job_acc;
                        init_q     <= job_init;
                        cnt        <= job_len;
                        len_zero_q <= (job_len == '0);
                    end
                end
                RUN: begin
                    if (op_valid) begin
                        cnt <= cnt - LEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    res_data <= zero_res ? '0 : mac_c;
                    res_err  <= (mode_q == 2'd3);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        mac_rst   = 1'b0;
        mac_en    = 1'b0;
        mac_b     = '0;
        mac_a0    = '0;
        mac_a1    = '0;
        mac_a2    = '0;
        mac_a3    = '0;
        mac_cfg   = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    job_ready = 1'b1;
                    if (job_valid) begin
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    mac_rst   = 1'b1;
                    mac_cfg   = {init_q, acc_q, mode_q};
                    state_nxt = len_zero_q ? DRAIN : RUN;
                end
                RUN: begin
                    op_ready = 1'b1;
                    mac_cfg  = {init_q, acc_q, mode_q};
                    if (op_valid) begin
                        mac_en = 1'b1;
                        mac_b  = op_b;
                        mac_a0 = op_a[MIN_WIDTH-1:0];
                        mac_a1 = op_a[2*MIN_WIDTH-1:MIN_WIDTH];
                        mac_a2 = op_a[3*MIN_WIDTH-1:2*MIN_WIDTH];
                        mac_a3 = op_a[4*MIN_WIDTH-1:3*MIN_WIDTH];
                        if (cnt == LEN_WIDTH'(1)) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    mac_cfg   = {init_q, acc_q, mode_q};
                    state_nxt = DONE;
                end
                DONE: begin
                    res_valid = 1'b1;
                    if (res_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural MAC block
// (registered output, cfg {init, acc, mode}) closing the loop on mac_c.
module tb_mac_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [1:0]  job_mode;
    logic        job_acc;
    logic [31:0] job_init;
    logic [15:0] job_len;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_b;
    logic [31:0] op_a;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic        mac_rst;
    logic        mac_en;
    logic [7:0]  mac_b;
    logic [7:0]  mac_a0;
    logic [7:0]  mac_a1;
    logic [7:0]  mac_a2;
    logic [7:0]  mac_a3;
    logic [34:0] mac_cfg;
    logic [31:0] mac_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_job_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_mode  (job_mode),
        .job_acc   (job_acc),
        .job_init  (job_init),
        .job_len   (job_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_b      (op_b),
        .op_a      (op_a),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .mac_rst   (mac_rst),
        .mac_en    (mac_en),
        .mac_b     (mac_b),
        .mac_a0    (mac_a0),
        .mac_a1    (mac_a1),
        .mac_a2    (mac_a2),
        .mac_a3    (mac_a3),
        .mac_cfg   (mac_cfg),
        .mac_c     (mac_c)
    );

    // MAC block model: SINGLE A2*B, DUAL A2*B + A3*B<<8, QUAD all four lanes.
    logic [31:0] prod;
    always_comb begin
        prod = '0;
        case (mac_cfg[1:0])
            2'd0: prod = 32'(mac_a2 * mac_b);
            2'd1: prod = 32'(mac_a2 * mac_b) + (32'(mac_a3 * mac_b) << 8);
            2'd2: prod = 32'(mac_a0 * mac_b) + (32'(mac_a1 * mac_b) << 8)
                       + (32'(mac_a2 * mac_b) << 16) + (32'(mac_a3 * mac_b) << 24);
            default: prod = 32'hdead_beef;
        endcase
    end

    always @(posedge clk) begin
        if (mac_rst)
            mac_c <= mac_cfg[34:3];
        else if (mac_en)
            mac_c <= mac_cfg[2] ? mac_c + prod : prod;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_job(input logic [1:0] mode, input logic acc,
                            input logic [31:0] init, input logic [15:0] len);
        job_mode  = mode;
        job_acc   = acc;
        job_init  = init;
        job_len   = len;
        job_valid = 1'b1;
        #1;
        check("job_ready", job_ready, 1);
        @(negedge clk);
        job_valid = 1'b0;
        job_init  = '0;
        job_len   = '0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [7:0] b, input int gap);
        int n;
        n = 0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            #1;
            check("gap_en", mac_en, 0);
        end
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        #1;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!op_ready)
            check("beat_timeout", 0, 1);
        check("fire_en", mac_en, 1);
        check("fire_b", mac_b, b);
        check("fire_a2", mac_a2, a[23:16]);
        @(negedge clk);
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
    endtask

    task automatic take_result(input string tag, input logic [31:0] data, input logic err);
        int n;
        n = 0;
        #1;
        while (!res_valid && n < 20) begin
            check({tag, "_no_opready"}, op_ready, 0);
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_data"}, res_data, data);
        check({tag, "_err"}, res_err, err);
        check({tag, "_cfg0"}, mac_cfg, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check({tag, "_drop"}, res_valid, 0);
        check({tag, "_idle"}, job_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        job_valid = 1'b0;
        job_mode  = '0;
        job_acc   = 1'b0;
        job_init  = '0;
        job_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_job_ready", job_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_cfg", mac_cfg, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("idle_job_ready", job_ready, 1);
        check("idle_op_ready", op_ready, 0);

        // SINGLE accumulate: 10 + 2*3 + 4*5 + 1*7
        send_job(2'd0, 1'b1, 32'd10, 16'd3);
        #1;
        check("load_mac_rst", mac_rst, 1);
        check("load_cfg", mac_cfg, {32'd10, 1'b1, 2'd0});
        check("load_job_ready", job_ready, 0);
        beat(32'h0002_0000, 8'd3, 0);
        beat(32'h0004_0000, 8'd5, 0);
        beat(32'h0001_0000, 8'd7, 0);
        #1;
        check("lat_drain", res_valid, 0);
        @(negedge clk);
        #1;
        check("lat_done", res_valid, 1);
        take_result("single", 32'd43, 1'b0);

        // DUAL multiply-only, gapped beats: last product 20 + (8<<8)
        send_job(2'd1, 1'b0, 32'd0, 16'd2);
        beat(32'h0103_0000, 8'd2, 3);
        beat(32'h0205_0000, 8'd4, 3);
        take_result("dual", 32'd2068, 1'b0);

        // QUAD accumulate with host backpressure
        send_job(2'd2, 1'b1, 32'd0, 16'd1);
        beat(32'h0101_0101, 8'd1, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, 32'h0101_0101);
            check("hold_job_ready", job_ready, 0);
        end
        take_result("quad", 32'h0101_0101, 1'b0);

        send_job(2'd0, 1'b1, 32'h55, 16'd0);
        take_result("len0_acc", 32'h55, 1'b0);

        send_job(2'd0, 1'b0, 32'h77, 16'd0);
        take_result("len0_mul", 32'd0, 1'b0);

        send_job(2'd3, 1'b1, 32'h99, 16'd2);
        beat(32'h0003_0000, 8'd3, 0);
        beat(32'h0005_0000, 8'd5, 0);
        take_result("mode3", 32'd0, 1'b1);

        // Reset in the middle of a 4-beat job
        send_job(2'd2, 1'b1, 32'd0, 16'd4);
        beat(32'h0101_0101, 8'd1, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_op_ready", op_ready, 0);
        check("mid_rst_mac_cfg", mac_cfg, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_idle", job_ready, 1);
        check("mid_rst_no_res", res_valid, 0);
        @(negedge clk);
        send_job(2'd0, 1'b1, 32'd1, 16'd1);
        beat(32'h0002_0000, 8'd2, 0);
        take_result("after_rst", 32'd5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
